// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory
// and presents instruction/PC/flush to decode with stall, redirect and a delivered counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_en,
  input  logic [31:0]          redirect_pc,
  output logic                 imem_rd_en,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          instruction_out,
  output logic [31:0]          pc_out,
  output logic                 id_flush,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [31:0]          req_pc_q, req_pc_d;
  logic                 req_valid_q, req_valid_d;
  logic [31:0]          hold_instr_q, hold_instr_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;

  logic [31:0] redirect_tgt;
  logic        out_valid;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign out_valid    = req_valid_q & ~rst;

  always_comb begin
    imem_addr  = redirect_en ? redirect_tgt : fetch_pc_q;
    imem_rd_en = ~rst & (redirect_en | ~stall);
    if (!out_valid) begin
      instruction_out = Nop;
    end else if (hold_valid_q) begin
      instruction_out = hold_instr_q;
    end else begin
      instruction_out = imem_rdata;
    end
    // req_pc is not yet defined during the very first reset cycle
    pc_out   = rst ? RESET_PC : req_pc_q;
    id_flush = rst | ~out_valid | redirect_en;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    req_valid_d   = req_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_valid_d  = hold_valid_q;
    instr_count_d = instr_count_q;
    if (redirect_en) begin
      req_pc_d     = redirect_tgt;
      req_valid_d  = 1'b1;
      fetch_pc_d   = redirect_tgt + 32'd4;
      hold_valid_d = 1'b0;
    end else if (stall) begin
      // Memory output is lost once the next read issues, so latch it on entry to a stall
      if (req_valid_q && !hold_valid_q) begin
        hold_instr_d = imem_rdata;
        hold_valid_d = 1'b1;
      end
    end else begin
      req_pc_d     = fetch_pc_q;
      req_valid_d  = 1'b1;
      fetch_pc_d   = fetch_pc_q + 32'd4;
      hold_valid_d = 1'b0;
    end
    if (out_valid && !stall && !redirect_en) begin
      instr_count_d = instr_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= RESET_PC;
      req_valid_q   <= 1'b0;
      hold_instr_q  <= Nop;
      hold_valid_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      req_valid_q   <= req_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_valid_q  <= hold_valid_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and drives a synchronous-read instruction memory with 1-cycle read latency.
- Presents instruction_out, pc_out and id_flush to decode. id_flush converts the decode input to NOP (0x00000013).
- Handles load-use stalls, EX-stage redirects (taken branch/jump), and keeps a delivered-instruction counter for benchmarking.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- CNT_WIDTH, 32, width of the delivered-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold the fetch PC and the instruction currently presented to decode.
- redirect_en  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  32  redirect target.
- imem_rd_en  output  1  instruction memory read request.
- imem_addr  output  32  instruction memory address, word aligned.
- imem_rdata  input  32  memory data, valid in the cycle after imem_rd_en.
- instruction_out  output  32  instruction to decode.
- pc_out  output  32  PC of instruction_out.
- id_flush  output  1  decode must treat instruction_out as NOP.
- instr_count  output  CNT_WIDTH  instructions delivered to decode.

Behaviour:
- State: fetch_pc, req_pc, req_valid, hold_instr, hold_valid, instr_count.
- Reset (rst=1 at clock edge):
  - fetch_pc=RESET_PC, req_pc=RESET_PC.
  - req_valid=0, hold_valid=0, instr_count=0.
  - While rst=1: imem_rd_en=0, id_flush=1, instruction_out=0x00000013, pc_out=RESET_PC.
  - Reset mid-operation discards any pending response.
- Address mux (combinational):
  - imem_addr = redirect_en ? {redirect_pc[31:2],2'b00} : fetch_pc.
  - imem_rd_en = !rst & (redirect_en | !stall).
  - redirect_pc[1:0] is ignored (forced to 00); there is no misalignment trap.
- Normal issue (imem_rd_en=1, no redirect): req_pc<=fetch_pc, req_valid<=1, fetch_pc<=fetch_pc+4 (wraps mod 2^32).
- Redirect (redirect_en=1): has priority over stall.
  - Aligned target T: req_pc<=T, req_valid<=1, fetch_pc<=T+4, hold_valid<=0.
  - id_flush=1 in the redirect cycle, killing the wrong-path instruction in decode.
  - mem[T] reaches decode the next cycle: 1-cycle bubble.
- Output selection:
  - out_valid = req_valid & !rst.
  - instruction_out = !out_valid ? 0x00000013 : (hold_valid ? hold_instr : imem_rdata).
  - pc_out = req_pc.
  - id_flush = rst | !out_valid | redirect_en.
- Stall (stall=1, redirect_en=0):
  - fetch_pc, req_pc and req_valid hold; imem_rd_en=0.
  - If req_valid & !hold_valid: hold_instr<=imem_rdata, hold_valid<=1. This captures the data before the memory output is lost.
  - instruction_out stays constant for the whole stall regardless of imem_rdata.
- Stall release: in the first cycle with stall=0, the held instruction is still presented and a new fetch issues. hold_valid<=0 at that edge.
- Stall and redirect in the same cycle: the redirect is applied and the stall is ignored.
- instr_count increments (wraps at 2^CNT_WIDTH) on an edge where out_valid & !stall & !redirect_en & !rst.
- Throughput: 1 instruction/cycle when no stall and no redirect. First instruction reaches decode 1 cycle after reset is released.

Test Plan:
- Reset release, no stall, memory holds words I0..I3 at 0x0,0x4,0x8,0xC -> cycle 0: id_flush=1, imem_addr=0x0. Cycles 1..4: instruction_out=I0..I3, pc_out=0x0..0xC, id_flush=0. instr_count=4 after cycle 4.
- Stall held 3 cycles while decode shows I1@0x4, memory bus driven with garbage during stall -> instruction_out=I1 and pc_out=0x4 throughout, imem_rd_en=0, fetch_pc unchanged. After release, next cycle shows I2@0x8; I1 is counted exactly once.
- redirect_en=1, redirect_pc=0x100 while decode shows I2@0x8 -> same cycle: id_flush=1, imem_addr=0x100. Next cycle: instruction_out=mem[0x100], pc_out=0x100. instr_count does not count I2.
- redirect_en=1 and stall=1 together, redirect_pc=0x203 -> redirect wins, imem_addr=0x200, next cycle pc_out=0x200, hold buffer cleared.
- rst asserted mid-stream while stall=1 -> next cycle imem_addr=RESET_PC, id_flush=1, instr_count=0, no stale held instruction after release.
- fetch_pc at 0xFFFFFFFC with no stall -> next fetch address 0x00000000. With CNT_WIDTH=4, the 16th delivered instruction wraps instr_count to 0.
